uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Asynchronous serial receiver, 8N1 format, LSB first, line idle high.
- Oversamples RXD_i with the system clock.
- Outputs each correctly framed byte on a held output bus, with a one-cycle DONE_o strobe.
- Sits at the serial input of the register/UART subsystem; paired with the matching UART transmitter in loopback benches.

Parameters:
- C_F_CK, 48_000_000, system clock frequency in Hz.
- C_BAUD, 115_200, baud rate in bit/s.
- C_DIV (derived, localparam), (C_F_CK + C_BAUD/2) / C_BAUD, clocks per bit (rounded). Must be >= 4.
- C_HALF (derived, localparam), C_DIV/2 (floor), clocks from start detection to the mid-start-bit sample.

Ports:
- CK_i  in  1  system clock, rising edge.
- XARST_i  in  1  asynchronous active-low reset.
- RXD_i  in  1  serial input; asynchronous to CK_i; idle = 1.
- BYTEs_o  out  8  last correctly received byte, held until the next valid frame.
- DONE_o  out  1  one-cycle strobe; asserted in the same cycle BYTEs_o first shows the new byte.

Behaviour:
- Reset (XARST_i=0, asynchronous): BYTEs_o=0, DONE_o=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame aborts the frame; no DONE_o is issued for it.
- Input synchronizer: two flops on RXD_i, reset value 1. The FSM uses only the second-stage output RXS.
- Bit counter: counts C_DIV-1 down to 0; a "tick" occurs when it reaches 0, then it reloads. Width is clog2(C_DIV).
- IDLE: wait for RXS==0.
  - On detection, load counter = C_HALF-1.
  - Go to START.
- START: at tick, sample RXS (mid start bit).
  - RXS==1: treat as a glitch and return to IDLE. No output change.
  - RXS==0: reload counter = C_DIV-1, clear bit index, go to DATA.
- DATA: at each tick, sample RXS into shift register position [index] (LSB first).
  - After 8 samples, go to STOP with counter = C_DIV-1.
- STOP: at tick, sample RXS (mid stop bit).
  - RXS==1: BYTEs_o <= shift register; DONE_o=1 for exactly the next cycle; go to IDLE.
  - RXS==0 (framing error): discard the byte, DONE_o stays 0, go to BREAK.
- BREAK: wait until RXS==1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Timing:
  - Let t0 be the first CK_i edge that samples RXD_i low after idle.
  - DONE_o is high in exactly one cycle, starting 3 + C_HALF + 9*C_DIV clocks after t0.
  - With C_DIV=10 this is 98 clocks.
- Back-to-back frames: after the stop sample, IDLE is entered half a bit early, so a start bit immediately following the stop bit is detected without loss.
- Baud tolerance: correct reception with up to ±4% total clock/baud mismatch. No resynchronization occurs within a frame.
- DONE_o is never asserted in two consecutive cycles.
- BYTEs_o changes only together with DONE_o.
- No parity, no FIFO, no overrun flag: a new byte simply overwrites BYTEs_o.

Test Plan:
- Reset: XARST_i=0 with RXD_i=1 → BYTEs_o=0x00, DONE_o=0. After release with the line idle for 200 clocks → DONE_o never asserts.
- Single frame: C_F_CK=1000, C_BAUD=100 (C_DIV=10); drive 0x5A as 8N1, 10 clocks/bit → one DONE_o pulse 98 clocks after t0, BYTEs_o=0x5A held afterwards.
- Loopback with the UART transmitter, sending bytes 0x00..0xFF consecutively with no idle gap → 256 DONE_o pulses, each BYTEs_o equal to the byte sent, in order.
- Glitch: RXD_i low for 3 clocks, then high → no DONE_o; the next valid frame 0xA5 is received correctly.
- Framing error: send 0x33 with stop bit 0, then hold low for 30 clocks, then high → no DONE_o and BYTEs_o unchanged. The next frame 0xC3 yields DONE_o with BYTEs_o=0xC3.
- Reset mid-frame: assert XARST_i during bit 4 of a frame → BYTEs_o=0, no DONE_o for that frame; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from a
// single bit-period down-counter, held byte output with a one-cycle DONE_o strobe.
module uart_rx_core #(
    parameter int unsigned C_F_CK = 48_000_000,
    parameter int unsigned C_BAUD = 115_200
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       RXD_i,
    output logic [7:0] BYTEs_o,
    output logic       DONE_o
);

    localparam int unsigned C_DIV  = (C_F_CK + C_BAUD / 2) / C_BAUD;
    localparam int unsigned C_HALF = C_DIV / 2;
    localparam int unsigned CNT_W  = $clog2(C_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tick_c;
    logic             frame_ok_c;
    logic             pend_q;
    logic             done_q;
    logic [7:0]       byte_q;

    assign tick_c = (cnt_q == '0);

    // FSM state register
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_c) begin
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick_c && (idx_q == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    state_d = rxs_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bit timer, bit index, shift register and frame-accept event
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_ok_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_d = CNT_W'(C_HALF - 1);
                end
            end
            S_START: begin
                cnt_d = tick_c ? CNT_W'(C_DIV - 1) : cnt_q - CNT_W'(1);
                if (tick_c) begin
                    idx_d = 3'd0;
                end
            end
            S_DATA: begin
                cnt_d = tick_c ? CNT_W'(C_DIV - 1) : cnt_q - CNT_W'(1);
                if (tick_c) begin
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                cnt_d = tick_c ? CNT_W'(C_DIV - 1) : cnt_q - CNT_W'(1);
                if (tick_c && rxs_q) begin
                    frame_ok_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Synchronizer and datapath registers; the accepted byte is published one
    // cycle after the stop sample so DONE_o and BYTEs_o update together.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            byte_q  <= '0;
        end else begin
            sync1_q <= RXD_i;
            rxs_q   <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pend_q  <= frame_ok_c;
            done_q  <= pend_q;
            if (pend_q) begin
                byte_q <= shift_q;
            end
        end
    end

    assign BYTEs_o = byte_q;
    assign DONE_o  = done_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an ideal 8N1 line driver pushes each byte
// that forms a valid frame; a monitor pops and compares on every DONE_o.
module tb_uart_rx_core;

    logic       CK_i;
    logic       XARST_i;
    logic       RXD_i;
    logic [7:0] BYTEs_o;
    logic       DONE_o;

    uart_rx_core #(
        .C_F_CK(1000),
        .C_BAUD(100)
    ) dut (
        .CK_i   (CK_i),
        .XARST_i(XARST_i),
        .RXD_i  (RXD_i),
        .BYTEs_o(BYTEs_o),
        .DONE_o (DONE_o)
    );

    localparam int EXP_LAT = 98;

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    int         done_seen  = 0;
    int         n_valid    = 0;
    int         last_done_cyc = -1;
    int         t0_cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good  = 8'h00;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_done  = 1'b0;

    initial CK_i = 1'b0;
    always #5 CK_i = ~CK_i;

    always @(posedge CK_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge CK_i) begin
        if (!XARST_i) begin
            prev_byte = 8'h00;
            prev_done = 1'b0;
        end else begin
            if (DONE_o) begin
                done_seen++;
                last_done_cyc = cyc;
                check("done_not_consecutive", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("byte_value", int'(BYTEs_o), int'(exp_q.pop_front()));
                end
            end else begin
                check("byte_held_without_done", int'(BYTEs_o), int'(prev_byte));
            end
            prev_byte = BYTEs_o;
            prev_done = DONE_o;
        end
    end

    // Drive one frame with a bit period of p10/10 clocks; abort_at >= 0 pulses
    // reset halfway through that bit position (0 = start, 1..8 = data, 9 = stop).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int p10, input int abort_at);
        logic [9:0] bits;
        int dur;
        bits = {stop_bit, b, 1'b0};
        if (stop_bit && abort_at < 0) begin
            exp_q.push_back(b);
            last_good = b;
            n_valid++;
        end
        t0_cyc = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            dur = ((i + 1) * p10 + 5) / 10 - (i * p10 + 5) / 10;
            RXD_i = bits[i];
            if (i == abort_at) begin
                repeat (dur / 2) @(negedge CK_i);
                XARST_i = 1'b0;
                RXD_i   = 1'b1;
                repeat (3) @(negedge CK_i);
                check("midframe_reset_byte", int'(BYTEs_o), 0);
                check("midframe_reset_done", int'(DONE_o), 0);
                last_good = 8'h00;
                XARST_i = 1'b1;
                return;
            end
            repeat (dur) @(negedge CK_i);
        end
    endtask

    task automatic idle(input int n);
        RXD_i = 1'b1;
        repeat (n) @(negedge CK_i);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CK_i);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        XARST_i = 1'b0;
        RXD_i   = 1'b1;
        repeat (3) @(negedge CK_i);
        check("reset_byte", int'(BYTEs_o), 0);
        check("reset_done", int'(DONE_o), 0);
        XARST_i = 1'b1;
        idle(200);
        check("idle_no_done", done_seen, 0);

        // Single frame: latency counted from the first edge that sees the line low
        send_frame(8'h5A, 1'b1, 100, -1);
        wait_drain(20, "single_frame_drain");
        check("single_frame_latency", last_done_cyc - t0_cyc, EXP_LAT);
        idle(30);
        check("single_frame_held", int'(BYTEs_o), 8'h5A);

        // Glitch shorter than half a bit, then a valid frame
        RXD_i = 1'b0;
        repeat (3) @(negedge CK_i);
        idle(20);
        check("glitch_no_done", done_seen, 1);
        send_frame(8'hA5, 1'b1, 100, -1);
        wait_drain(20, "after_glitch_drain");

        // Framing error followed by a held-low line
        send_frame(8'h33, 1'b0, 100, -1);
        RXD_i = 1'b0;
        repeat (30) @(negedge CK_i);
        idle(20);
        check("framing_err_no_done", done_seen, 2);
        check("framing_err_byte_kept", int'(BYTEs_o), int'(last_good));
        send_frame(8'hC3, 1'b1, 100, -1);
        wait_drain(20, "after_framing_drain");

        // Reset during data bit 4, then a clean frame
        idle(10);
        send_frame(8'h6C, 1'b1, 100, 5);
        idle(20);
        check("after_reset_byte", int'(BYTEs_o), 0);
        send_frame(8'h81, 1'b1, 100, -1);
        wait_drain(20, "after_reset_drain");

        // Loopback-style burst 0x00..0xFF with no idle gap
        idle(10);
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1, 100, -1);
        end
        wait_drain(20, "burst_drain");

        // Random bytes, random gaps, bit period within +/-4% of nominal
        for (int k = 0; k < 60; k++) begin
            idle($urandom_range(15, 0));
            send_frame(8'($urandom_range(255, 0)), 1'b1, $urandom_range(104, 96), -1);
        end
        wait_drain(20, "random_drain");

        idle(20);
        check("done_count", done_seen, n_valid);
        check("final_byte", int'(BYTEs_o), int'(last_good));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
